// File: rtl/pipe_mem_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data access.
// It also derives the per-stage pipeline stall controls.
module pipe_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_Req,
  input  logic [31:0] IF_Addr,
  input  logic        MEM_Req,
  input  logic        MEM_Write,
  input  logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_WData,
  input  logic [3:0]  MEM_ByteEn,
  input  logic        ID_LoadUse,
  input  logic        EX_Busy,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic [31:0] IF_RData,
  output logic [31:0] MEM_RData,
  output logic        IF_Stall,
  output logic        ID_Stall,
  output logic        EX_Stall,
  output logic        MEM_Stall,
  output logic        WB_Stall
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_e;

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [DW-1:0]     bus_addr_q, bus_addr_d;
  logic [DW-1:0]     bus_wdata_q, bus_wdata_d;
  logic [BW-1:0]     bus_be_q, bus_be_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic [DW-1:0]     mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  // Stall controls are combinational from registered done flags and live requests.
  assign MEM_Stall = MEM_Req & ~mem_done_q;
  assign EX_Stall  = MEM_Stall | EX_Busy;
  assign ID_Stall  = EX_Stall | ID_LoadUse;
  assign IF_Stall  = IF_Req & ~if_done_q;
  assign WB_Stall  = 1'b0;

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
  assign IF_RData  = if_rdata_q;
  assign MEM_RData = mem_rdata_q;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;

    // MEM/WB consumes load data on the first edge; IF/ID only when ID advances.
    if (mem_done_q) mem_done_d = 1'b0;
    if (if_done_q && !ID_Stall) if_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (MEM_Req && !mem_done_q) begin
          state_d     = MEM_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = MEM_Write;
          bus_addr_d  = MEM_Addr;
          bus_wdata_d = MEM_WData;
          bus_be_d    = MEM_Write ? MEM_ByteEn : BW'(4'hF);
        end else if (IF_Req && !if_done_q) begin
          state_d     = IF_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = IF_Addr;
          bus_be_d    = BW'(4'hF);
        end
      end
      IF_BUSY: begin
        if (bus_ack) begin
          state_d    = IDLE;
          bus_req_d  = 1'b0;
          if_rdata_d = bus_rdata;
          if_done_d  = 1'b1;
        end
      end
      MEM_BUSY: begin
        if (bus_ack) begin
          state_d     = IDLE;
          bus_req_d   = 1'b0;
          mem_rdata_d = bus_rdata;
          mem_done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

endmodule

// File: doc/pipe_mem_arbiter.md
# pipe_mem_arbiter

Shares one single-ported memory bus between instruction fetch (IF) and data access (MEM). It also generates the per-stage stall signals that drive the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sits beside the pipeline registers in the CPU top level, between the IF/MEM stages and the external memory bus. It owns all memory-wait and load-use stall sequencing.

## Interface
- No parameters; address/data width fixed at 32.
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- IF_Req  in  1  fetch wants the instruction at IF_Addr
- IF_Addr  in  32  fetch address (word aligned)
- MEM_Req  in  1  MEM stage has a load or store (MemRead | MemWrite)
- MEM_Write  in  1  1 = store, 0 = load
- MEM_Addr  in  32  data address
- MEM_WData  in  32  store data
- MEM_ByteEn  in  4  store byte enables
- ID_LoadUse  in  1  load-use hazard detected in ID
- EX_Busy  in  1  multi-cycle EX operation not finished
- bus_ack  in  1  one-cycle completion pulse from memory
- bus_rdata  in  32  read data, valid with bus_ack
- bus_req  out  1  request, held until bus_ack
- bus_we  out  1  write strobe
- bus_addr  out  32  address
- bus_wdata  out  32  write data
- bus_be  out  4  byte enables (4'hF for fetch/load)
- IF_RData  out  32  latched instruction
- MEM_RData  out  32  latched load data
- IF_Stall, ID_Stall, EX_Stall, MEM_Stall, WB_Stall  out  1 each  stage stall controls

## Operation
- FSM states: IDLE, IF_BUSY, MEM_BUSY. State, bus outputs and done flags are registered.
- Done flags: if_done and mem_done mark a completed access that the pipeline has not yet consumed.
- IDLE transitions:
  - MEM_Req & !mem_done -> MEM_BUSY. Latch MEM_Addr/WData/ByteEn/Write into bus regs.
  - else IF_Req & !if_done -> IF_BUSY. Latch IF_Addr, we=0, be=4'hF.
  - MEM has strict priority: it holds the older instruction.
- BUSY states:
  - bus_req=1 with stable address/data.
  - On bus_ack: capture bus_rdata into IF_RData or MEM_RData, set the matching done flag, drop bus_req, return to IDLE.
- bus_ack is ignored while in IDLE.
- Stall equations (combinational from registered state plus inputs):
  - MEM_Stall = MEM_Req & !mem_done
  - EX_Stall = MEM_Stall | EX_Busy
  - ID_Stall = EX_Stall | ID_LoadUse
  - IF_Stall = IF_Req & !if_done
  - WB_Stall = 0
- Done-flag clearing:
  - mem_done clears on the edge where it is 1 (the MEM/WB register captures that edge).
  - if_done clears on an edge where if_done=1 and ID_Stall=0.
  - While ID_Stall=1, if_done and IF_RData hold.
- A store completes like a load. MEM_RData is then don't-care, but is still updated.

## Timing
- Reset values (asynchronous, rst=0):
  - state=IDLE
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0
  - IF_RData=0, MEM_RData=0, if_done=0, mem_done=0
  - IF_Stall/MEM_Stall follow their equations, so they reflect the inputs combinationally even during reset.
- Access latency:
  - Request seen in IDLE at cycle 0.
  - bus_req high from cycle 1.
  - bus_ack at cycle n≥1 -> done flag and data valid at cycle n+1.
  - The stage stall drops in cycle n+1.
  - Minimum stall is 2 cycles per access.
- Simultaneous IF_Req and MEM_Req in IDLE: MEM is served first. The IF access follows the cycle after MEM returns to IDLE.
- A new request is never accepted in the cycle bus_ack arrives; the FSM must pass through IDLE.
- Reset mid-access:
  - Abandon immediately, bus_req=0.
  - A late bus_ack after reset release is ignored in IDLE.
- IF_Req dropped during IF_BUSY (e.g. on a flush): the access still completes and if_done is set. The stale data is discarded by the flushed IF/ID path.
- A request that is already done is not re-issued while its done flag is set.

## Test plan
- Reset with rst=0 mid-IF_BUSY (bus_req=1) -> all outputs at reset values next sample. After release, an ack pulse in IDLE changes nothing.
- IF_Req=1, IF_Addr=0x0000_0040, ack 3 cycles after bus_req -> bus_addr=0x40, be=4'hF, we=0. IF_Stall high 4 cycles. IF_RData=bus_rdata (0x2402_0005) when IF_Stall falls.
- IF_Req and MEM_Req (load, addr 0x100) both asserted in IDLE -> MEM access first. MEM_Stall, EX_Stall and ID_Stall high until MEM done. IF access starts the cycle after MEM returns to IDLE.
- Store: MEM_Write=1, addr 0x204, wdata 0xDEAD_BEEF, be=4'b0011, ack after 1 cycle -> bus_we=1, bus_be=4'b0011. MEM_Stall high exactly 2 cycles.
- if_done set while ID_LoadUse=1 for 2 cycles -> IF_RData and if_done held, IF_Stall=0, no new fetch issued. Clears on the first edge with ID_Stall=0.
- EX_Busy=1 with no memory traffic -> EX_Stall=ID_Stall=1, MEM_Stall=IF_Stall=WB_Stall=0, bus_req stays 0.
